// File: rtl/nmi_arbiter_pkg.sv
// Shared types and constants for the NMI sharing logic.
package nmi_arbiter_pkg;

  typedef enum logic [2:0] {
    NMI_IDLE     = 3'd0,
    NMI_WAIT_INT = 3'd1,
    NMI_ASSERT   = 3'd2,
    NMI_SERVICE  = 3'd3,
    NMI_DRAIN    = 3'd4
  } nmi_state_t;

  localparam logic [15:0] NMI_VECTOR = 16'h0066;
  localparam int          TIMER_W    = 20;

  // True on the opcode fetch of the NMI vector: the CPU has taken the NMI.
  function automatic logic is_nmi_fetch(input logic m1, input logic memreq,
                                        input logic [15:0] addr);
    return m1 && memreq && (addr == NMI_VECTOR);
  endfunction

endpackage

// File: rtl/nmi_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         win_oh,
  output logic [$clog2(N)-1:0] win_id,
  output logic                 win_any
);

  localparam int W = $clog2(N);

  int unsigned  pos_s;
  logic [W-1:0] idx_s;

  // Scan N positions starting one past the previous owner; first hit wins.
  always_comb begin
    win_oh  = '0;
    win_id  = '0;
    win_any = 1'b0;
    pos_s   = 32'd0;
    idx_s   = '0;
    for (int k = 1; k <= N; k++) begin
      pos_s = 32'(last) + 32'(k);
      if (pos_s >= 32'(N)) begin
        pos_s = pos_s - 32'(N);
      end else begin
        pos_s = pos_s;
      end
      idx_s = W'(pos_s);
      if (!win_any && req[idx_s]) begin
        win_any       = 1'b1;
        win_oh[idx_s] = 1'b1;
        win_id        = idx_s;
      end else begin
        win_any = win_any;
      end
    end
  end

endmodule

// File: rtl/nmi_arbiter.sv
// Shares the Z80 /NMI line between several requesters: latch, round-robin
// grant, time the assertion to the frame interrupt, hold until end of service.
module nmi_arbiter
  import nmi_arbiter_pkg::*;
#(
  parameter int          NSRC    = 3,
  parameter logic [19:0] TIMEOUT = 20'd560000
) (
  input  logic                    clk28,
  input  logic                    rst_n,
  input  logic                    bus_memreq,
  input  logic                    bus_m1,
  input  logic [15:0]             bus_a_reg,
  input  logic                    n_int,
  input  logic                    n_int_next,
  input  logic [NSRC-1:0]         req,
  input  logic [NSRC-1:0]         svc_release,
  output logic                    n_nmi,
  output logic                    grant_valid,
  output logic [$clog2(NSRC)-1:0] grant_id,
  output logic [NSRC-1:0]         grant_oh,
  output logic [NSRC-1:0]         pending,
  output logic                    nmi_entry,
  output logic                    timeout
);

  localparam int               IDW      = $clog2(NSRC);
  localparam logic [IDW-1:0]   LAST_RST = IDW'(NSRC - 1);

  nmi_state_t         state_r, state_s;
  logic [TIMER_W-1:0] timer_r, timer_s;
  logic [NSRC-1:0]    req_d_r, pending_r, pending_s, req_rise_s, pend_clr_s;
  logic [NSRC-1:0]    grant_oh_r, grant_oh_s, win_oh_s;
  logic [IDW-1:0]     grant_id_r, grant_id_s, last_owner_r, last_owner_s, win_id_s;
  logic               grant_valid_r, grant_valid_s;
  logic               n_nmi_r, n_nmi_s;
  logic               nmi_entry_r, nmi_entry_s;
  logic               timeout_r, timeout_s;
  logic               fetch_s, win_any_s, frame_edge_s, owner_rel_s;

  rr_arbiter #(.N(NSRC)) u_rr (
    .req     (pending_r),
    .last    (last_owner_r),
    .win_oh  (win_oh_s),
    .win_id  (win_id_s),
    .win_any (win_any_s)
  );

  // Next-state and next-output logic for the grant FSM.
  always_comb begin
    req_rise_s    = req & ~req_d_r;
    fetch_s       = is_nmi_fetch(bus_m1, bus_memreq, bus_a_reg);
    frame_edge_s  = n_int && !n_int_next;
    owner_rel_s   = svc_release[grant_id_r];
    state_s       = state_r;
    timer_s       = timer_r;
    grant_valid_s = grant_valid_r;
    grant_id_s    = grant_id_r;
    grant_oh_s    = grant_oh_r;
    last_owner_s  = last_owner_r;
    n_nmi_s       = n_nmi_r;
    nmi_entry_s   = 1'b0;
    timeout_s     = 1'b0;
    pend_clr_s    = '0;
    case (state_r)
      NMI_IDLE: begin
        if (win_any_s) begin
          grant_id_s    = win_id_s;
          grant_oh_s    = win_oh_s;
          grant_valid_s = 1'b1;
          pend_clr_s    = win_oh_s;
          state_s       = NMI_WAIT_INT;
        end else begin
          state_s = NMI_IDLE;
        end
      end
      NMI_WAIT_INT: begin
        if (frame_edge_s) begin
          n_nmi_s = 1'b0;
          timer_s = '0;
          state_s = NMI_ASSERT;
        end else begin
          state_s = NMI_WAIT_INT;
        end
      end
      NMI_ASSERT: begin
        // A vector fetch on the final cycle still counts as taken.
        if (fetch_s) begin
          n_nmi_s     = 1'b1;
          nmi_entry_s = 1'b1;
          state_s     = NMI_SERVICE;
        end else if (timer_r == (TIMEOUT - 20'd1)) begin
          n_nmi_s       = 1'b1;
          timeout_s     = 1'b1;
          grant_valid_s = 1'b0;
          grant_oh_s    = '0;
          last_owner_s  = grant_id_r;
          state_s       = NMI_IDLE;
        end else begin
          timer_s = timer_r + 20'd1;
        end
      end
      NMI_SERVICE: begin
        if (owner_rel_s) begin
          state_s = NMI_DRAIN;
        end else begin
          state_s = NMI_SERVICE;
        end
      end
      NMI_DRAIN: begin
        // Never hand the mapping over in the middle of a memory cycle.
        if (!bus_memreq) begin
          grant_valid_s = 1'b0;
          grant_oh_s    = '0;
          last_owner_s  = grant_id_r;
          state_s       = NMI_IDLE;
        end else begin
          state_s = NMI_DRAIN;
        end
      end
      default: begin
        n_nmi_s       = 1'b1;
        grant_valid_s = 1'b0;
        grant_oh_s    = '0;
        state_s       = NMI_IDLE;
      end
    endcase
    // A fresh edge on the source being granted stays pending.
    pending_s = (pending_r & ~pend_clr_s) | req_rise_s;
  end

  // State, timer, request latches and registered outputs.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= NMI_IDLE;
      timer_r       <= '0;
      req_d_r       <= '0;
      pending_r     <= '0;
      grant_valid_r <= 1'b0;
      grant_id_r    <= '0;
      grant_oh_r    <= '0;
      last_owner_r  <= LAST_RST;
      n_nmi_r       <= 1'b1;
      nmi_entry_r   <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      timer_r       <= timer_s;
      req_d_r       <= req;
      pending_r     <= pending_s;
      grant_valid_r <= grant_valid_s;
      grant_id_r    <= grant_id_s;
      grant_oh_r    <= grant_oh_s;
      last_owner_r  <= last_owner_s;
      n_nmi_r       <= n_nmi_s;
      nmi_entry_r   <= nmi_entry_s;
      timeout_r     <= timeout_s;
    end
  end

  assign n_nmi       = n_nmi_r;
  assign grant_valid = grant_valid_r;
  assign grant_id    = grant_id_r;
  assign grant_oh    = grant_oh_r;
  assign pending     = pending_r;
  assign nmi_entry   = nmi_entry_r;
  assign timeout     = timeout_r;

endmodule

// File: tb/tb_nmi_arbiter.sv
// Scoreboard bench for nmi_arbiter: expected grant order is queued at request
// time and checked when grant_valid rises.
module tb_nmi_arbiter;

  localparam int          NSRC = 3;
  localparam logic [19:0] TMO  = 20'd100;

  logic              clk28 = 1'b0;
  logic              rst_n;
  logic              bus_memreq, bus_m1;
  logic [15:0]       bus_a_reg;
  logic              n_int, n_int_next;
  logic [NSRC-1:0]   req, svc_release;
  logic              n_nmi, grant_valid, nmi_entry, timeout;
  logic [1:0]        grant_id;
  logic [NSRC-1:0]   grant_oh, pending;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int exp_q[$];
  logic gv_prev = 1'b0;

  nmi_arbiter #(.NSRC(NSRC), .TIMEOUT(TMO)) dut (
    .clk28       (clk28),
    .rst_n       (rst_n),
    .bus_memreq  (bus_memreq),
    .bus_m1      (bus_m1),
    .bus_a_reg   (bus_a_reg),
    .n_int       (n_int),
    .n_int_next  (n_int_next),
    .req         (req),
    .svc_release (svc_release),
    .n_nmi       (n_nmi),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .grant_oh    (grant_oh),
    .pending     (pending),
    .nmi_entry   (nmi_entry),
    .timeout     (timeout)
  );

  always #5 clk28 = ~clk28;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk28);
  endtask

  // Scoreboard: pop the expected owner whenever a new grant appears.
  always @(negedge clk28) begin
    int e;
    if (rst_n === 1'b1 && grant_valid === 1'b1 && gv_prev === 1'b0) begin
      if (exp_q.size() == 0) begin
        check_val("grant_unexpected", 32'(grant_id), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_val("grant_id", 32'(grant_id), 32'(e));
        check_val("grant_oh", 32'(grant_oh), 32'd1 << e);
      end
    end
    gv_prev = grant_valid;
  end

  task automatic wait_gv(input logic v, input string tag);
    int n = 0;
    while (grant_valid !== v && n < 20) begin
      tick(1);
      n++;
    end
    check_val(tag, 32'(grant_valid), 32'(v));
  endtask

  task automatic frame_edge();
    n_int_next = 1'b0;
    tick(1);
    n_int_next = 1'b1;
  endtask

  task automatic fetch(input logic [15:0] addr);
    bus_m1 = 1'b1; bus_memreq = 1'b1; bus_a_reg = addr;
    tick(1);
    bus_m1 = 1'b0; bus_memreq = 1'b0; bus_a_reg = 16'h0000;
  endtask

  task automatic to_service(input int id);
    frame_edge();
    check_val("svc_nmi_low", 32'(n_nmi), 32'd0);
    tick(2);
    fetch(16'h0066);
    check_val("svc_entry", 32'(nmi_entry), 32'd1);
    check_val("svc_nmi_high", 32'(n_nmi), 32'd1);
    check_val("svc_oh", 32'(grant_oh), 32'd1 << id);
  endtask

  task automatic serve(input int id);
    to_service(id);
    svc_release = NSRC'(1 << id);
    tick(1);
    svc_release = '0;
    wait_gv(1'b0, "svc_drop");
    check_val("svc_id_hold", 32'(grant_id), 32'(id));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt;
    int bad;
    rst_n = 1'b0; bus_memreq = 1'b0; bus_m1 = 1'b0; bus_a_reg = 16'h0000;
    n_int = 1'b1; n_int_next = 1'b1; req = '0; svc_release = '0;
    tick(2);
    check_val("rst_n_nmi", 32'(n_nmi), 32'd1);
    check_val("rst_gv", 32'(grant_valid), 32'd0);
    check_val("rst_id", 32'(grant_id), 32'd0);
    check_val("rst_oh", 32'(grant_oh), 32'd0);
    check_val("rst_pending", 32'(pending), 32'd0);
    check_val("rst_entry", 32'(nmi_entry), 32'd0);
    check_val("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Round robin from last owner 2: expect 0, 1, 2.
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    req = 3'b111; tick(1); req = '0;
    check_val("rr_pend0", 32'(pending), 32'b111);
    tick(1);
    check_val("rr_pend1", 32'(pending), 32'b110);
    serve(0); tick(1);
    check_val("rr_pend2", 32'(pending), 32'b100);
    serve(1); tick(1);
    check_val("rr_pend3", 32'(pending), 32'b000);
    serve(2);

    // Single request with detailed timing.
    exp_q.push_back(1);
    req = 3'b010; tick(1); req = '0;
    check_val("one_pend", 32'(pending), 32'b010);
    tick(1);
    check_val("one_gv", 32'(grant_valid), 32'd1);
    tick(3);
    check_val("one_wait_nmi", 32'(n_nmi), 32'd1);
    frame_edge();
    check_val("one_nmi_low", 32'(n_nmi), 32'd0);
    fetch(16'h0067);
    check_val("one_wrong_addr_entry", 32'(nmi_entry), 32'd0);
    check_val("one_wrong_addr_nmi", 32'(n_nmi), 32'd0);
    fetch(16'h0066);
    check_val("one_entry", 32'(nmi_entry), 32'd1);
    check_val("one_nmi_rel", 32'(n_nmi), 32'd1);
    check_val("one_oh", 32'(grant_oh), 32'b010);
    svc_release = 3'b010; tick(1); svc_release = '0;
    check_val("one_entry_pulse", 32'(nmi_entry), 32'd0);
    tick(1);
    check_val("one_gv_drop", 32'(grant_valid), 32'd0);
    check_val("one_oh_drop", 32'(grant_oh), 32'd0);
    check_val("one_id_hold", 32'(grant_id), 32'd1);

    // Foreign release ignored; drain waits for memreq low.
    exp_q.push_back(0);
    req = 3'b001; tick(1); req = '0; tick(1);
    to_service(0);
    svc_release = 3'b110; tick(2); svc_release = '0;
    check_val("foreign_gv", 32'(grant_valid), 32'd1);
    check_val("foreign_oh", 32'(grant_oh), 32'b001);
    bus_memreq = 1'b1; svc_release = 3'b001; tick(1); svc_release = '0;
    tick(3);
    check_val("drain_hold", 32'(grant_valid), 32'd1);
    bus_memreq = 1'b0; tick(1);
    check_val("drain_done", 32'(grant_valid), 32'd0);

    // Timeout: owner 1 abandoned after TMO low cycles, then 0 is served.
    exp_q.push_back(1); exp_q.push_back(0);
    req = 3'b011; tick(1); req = '0; tick(1);
    check_val("to_pend", 32'(pending), 32'b001);
    frame_edge();
    low_cnt = 0;
    while (n_nmi === 1'b0 && low_cnt < 300) begin
      low_cnt++;
      tick(1);
    end
    check_val("to_low_cycles", 32'(low_cnt), 32'(TMO));
    check_val("to_pulse", 32'(timeout), 32'd1);
    check_val("to_gv", 32'(grant_valid), 32'd0);
    check_val("to_not_restored", 32'(pending), 32'b001);
    tick(1);
    check_val("to_pulse_end", 32'(timeout), 32'd0);
    check_val("to_next_pend", 32'(pending), 32'b000);
    serve(0);

    // Re-request by owner 2 during service; 0 goes first afterwards.
    exp_q.push_back(2);
    req = 3'b100; tick(1); req = '0; tick(1);
    to_service(2);
    req = 3'b100; tick(1); req = '0;
    check_val("rereq_pend", 32'(pending), 32'b100);
    req = 3'b001; tick(1); req = '0;
    check_val("rereq_pend2", 32'(pending), 32'b101);
    exp_q.push_back(0); exp_q.push_back(2);
    svc_release = 3'b100; tick(1); svc_release = '0;
    wait_gv(1'b0, "rereq_drop");
    tick(1);
    check_val("rereq_after0", 32'(pending), 32'b100);
    serve(0); tick(1);
    check_val("rereq_after2", 32'(pending), 32'b000);
    serve(2);

    // Asynchronous reset in the middle of ASSERT.
    exp_q.push_back(1);
    req = 3'b010; tick(1); req = '0; tick(1);
    frame_edge();
    check_val("ar_nmi_low", 32'(n_nmi), 32'd0);
    req = 3'b001; tick(1); req = '0;
    check_val("ar_pend", 32'(pending), 32'b001);
    #2 rst_n = 1'b0;
    #1;
    check_val("ar_nmi", 32'(n_nmi), 32'd1);
    check_val("ar_gv", 32'(grant_valid), 32'd0);
    check_val("ar_id", 32'(grant_id), 32'd0);
    check_val("ar_oh", 32'(grant_oh), 32'd0);
    check_val("ar_pending", 32'(pending), 32'd0);
    tick(2);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      n_int_next = (i % 10 == 5) ? 1'b0 : 1'b1;
      tick(1);
      if (n_nmi !== 1'b1) bad++;
      if (grant_valid !== 1'b0) bad++;
    end
    n_int_next = 1'b1;
    check_val("ar_quiet", 32'(bad), 32'd0);
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
